ft600_bus_scheduler: RTL and testbench

Sequences the shared 16-bit FT600-style synchronous FIFO bus between the read (host→FPGA) and write (FPGA→host) directions. It owns OE_N/RD_N/WR_N and the DATA/BE tristates. It arbitrates read versus write bursts with alternating priority and a burst-length cap, and inserts a bus-turnaround cycle after every burst. Sits between the USB chip pins and the FPGA-side RX sink / TX source streams.

---
 rtl/ft600_bus_scheduler_pkg.sv | 22 ++
 rtl/ft600_bus_scheduler_if.sv | 27 ++
 rtl/ft600_bus_scheduler_io_pad.sv | 19 +
 rtl/ft600_bus_scheduler.sv | 154 +++++++++++++++
 tb/tb_ft600_bus_scheduler.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ft600_bus_scheduler_pkg.sv
// Shared types and constants for the FT600 bus scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ft600_pkg;
  localparam int DATA_W        = 16;
  localparam int BE_W          = 2;
  localparam int DEF_MAX_BURST = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_OE,
    ST_RD_DATA,
    ST_RD_END,
    ST_WR_DATA,
    ST_WR_END
  } state_t;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_t;
endpackage

// File: rtl/ft600_bus_scheduler_if.sv
// FPGA-side stream bundle: RX sink (captured words) and TX source (words to send).
// Latency: n/a (wiring only).
// Backpressure: RX has none (rx_space gates bursts up front); TX uses tx_valid/tx_ready.
interface ft600_bus_scheduler_if;
  import ft600_pkg::*;

  logic              rx_space;
  logic [DATA_W-1:0] rx_data;
  logic [BE_W-1:0]   rx_be;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic [BE_W-1:0]   tx_be;
  logic              tx_valid;
  logic              tx_ready;

  // Stream user: provides TX words and RX space, consumes RX words.
  modport master (
    output rx_space, tx_data, tx_be, tx_valid,
    input  rx_data, rx_be, rx_valid, tx_ready
  );

  // Scheduler side.
  modport slave (
    input  rx_space, tx_data, tx_be, tx_valid,
    output rx_data, rx_be, rx_valid, tx_ready
  );
endinterface

// File: rtl/ft600_bus_scheduler_io_pad.sv
// DATA/BE tristate drivers and input path; kept separate so pad primitives can be swapped per target.
// Latency: combinational.
// Backpressure: none.
module ft600_io_pad
  import ft600_pkg::*;
(
  input  logic              drv_en_i,
  input  logic [DATA_W-1:0] data_out_i,
  input  logic [BE_W-1:0]   be_out_i,
  output logic [DATA_W-1:0] data_in_o,
  output logic [BE_W-1:0]   be_in_o,
  inout  wire  [DATA_W-1:0] data_io,
  inout  wire  [BE_W-1:0]   be_io
);
  assign data_io   = drv_en_i ? data_out_i : {DATA_W{1'bz}};
  assign be_io     = drv_en_i ? be_out_i   : {BE_W{1'bz}};
  assign data_in_o = data_io;
  assign be_in_o   = be_io;
endmodule

// File: rtl/ft600_bus_scheduler.sv
// Arbitrates the shared FT600 FIFO bus between read and write bursts, with turnaround after each burst.
// Latency: read capture 2 edges after request sampled, rx_valid the cycle after; write first transfer 1 edge after request.
// Backpressure: RX none (burst only starts with rx_space); TX stalls on TXE_N via tx_ready, burst capped at MAX_BURST.
module ft600_bus_scheduler
  import ft600_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_W     = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  RXF_N,
  input  logic                  TXE_N,
  output logic                  OE_N,
  output logic                  RD_N,
  output logic                  WR_N,
  inout  wire  [DATA_W-1:0]     DATA,
  inout  wire  [BE_W-1:0]       BE,
  ft600_bus_scheduler_if.slave  strm,
  output logic                  busy,
  output logic [CNT_W-1:0]      rx_words,
  output logic [CNT_W-1:0]      tx_words
);
  localparam logic [15:0]      LAST_CNT = 16'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  dir_t              last_dir_q, last_dir_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_data_q;
  logic [BE_W-1:0]   rx_be_q;
  logic              rx_valid_q;
  logic [CNT_W-1:0]  rx_words_q, tx_words_q;

  logic              drv_en;
  logic              rd_cap;
  logic              wr_xfer;
  logic [DATA_W-1:0] pad_data;
  logic [BE_W-1:0]   pad_be;

  wire rd_req = !RXF_N && strm.rx_space;
  wire wr_req = !TXE_N && strm.tx_valid;

  ft600_io_pad u_pad (
    .drv_en_i   (drv_en),
    .data_out_i (strm.tx_data),
    .be_out_i   (strm.tx_be),
    .data_in_o  (pad_data),
    .be_in_o    (pad_be),
    .data_io    (DATA),
    .be_io      (BE)
  );

  // Next state, strobes and transfer qualifiers; strobes default inactive.
  always_comb begin
    state_d       = state_q;
    last_dir_d    = last_dir_q;
    cnt_d         = cnt_q;
    OE_N          = 1'b1;
    RD_N          = 1'b1;
    WR_N          = 1'b1;
    drv_en        = 1'b0;
    strm.tx_ready = 1'b0;
    rd_cap        = 1'b0;
    wr_xfer       = 1'b0;
    busy          = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        // On contention the direction not served last time wins.
        if (rd_req && (!wr_req || last_dir_q == DIR_WRITE)) begin
          state_d = ST_RD_OE;
          cnt_d   = '0;
        end else if (wr_req) begin
          state_d = ST_WR_DATA;
          cnt_d   = '0;
        end
      end
      ST_RD_OE: begin
        OE_N    = 1'b0;
        state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        OE_N = 1'b0;
        RD_N = 1'b0;
        if (RXF_N) begin
          state_d = ST_RD_END;
        end else begin
          rd_cap = 1'b1;
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q == LAST_CNT) state_d = ST_RD_END;
        end
      end
      ST_RD_END: begin
        state_d    = ST_IDLE;
        last_dir_d = DIR_READ;
      end
      ST_WR_DATA: begin
        drv_en        = 1'b1;
        strm.tx_ready = !TXE_N;
        WR_N          = !(strm.tx_valid && !TXE_N);
        if (TXE_N || !strm.tx_valid) begin
          state_d = ST_WR_END;
        end else begin
          wr_xfer = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          if (cnt_q == LAST_CNT) state_d = ST_WR_END;
        end
      end
      ST_WR_END: begin
        state_d    = ST_IDLE;
        last_dir_d = DIR_WRITE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, burst count and served-direction registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      last_dir_q <= DIR_WRITE;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      cnt_q      <= cnt_d;
    end
  end

  // Read capture, one-cycle rx_valid pulse and free-running word counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_data_q  <= '0;
      rx_be_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_words_q <= '0;
      tx_words_q <= '0;
    end else begin
      rx_valid_q <= rd_cap;
      if (rd_cap) begin
        rx_data_q  <= pad_data;
        rx_be_q    <= pad_be;
        rx_words_q <= rx_words_q + CNT_ONE;
      end
      if (wr_xfer) tx_words_q <= tx_words_q + CNT_ONE;
    end
  end

  assign strm.rx_data  = rx_data_q;
  assign strm.rx_be    = rx_be_q;
  assign strm.rx_valid = rx_valid_q;
  assign rx_words      = rx_words_q;
  assign tx_words      = tx_words_q;
endmodule

// File: tb/tb_ft600_bus_scheduler.sv
// Scoreboard bench: host FT600 model plus stream source/sink around the scheduler.
// Latency: n/a.
// Backpressure: host presents RXF_N/TXE_N from its own queues and enables.
module tb_ft600_bus_scheduler;
  import ft600_pkg::*;

  localparam int MB = 4;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          RXF_N, TXE_N;
  logic          OE_N, RD_N, WR_N;
  wire  [15:0]   DATA;
  wire  [1:0]    BE;
  logic          busy;
  logic [CW-1:0] rx_words, tx_words;
  logic [15:0]   host_data;
  logic [1:0]    host_be;

  ft600_bus_scheduler_if strm ();

  ft600_bus_scheduler #(.MAX_BURST(MB), .CNT_W(CW)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .RXF_N    (RXF_N),
    .TXE_N    (TXE_N),
    .OE_N     (OE_N),
    .RD_N     (RD_N),
    .WR_N     (WR_N),
    .DATA     (DATA),
    .BE       (BE),
    .strm     (strm),
    .busy     (busy),
    .rx_words (rx_words),
    .tx_words (tx_words)
  );

  always #5 CLK = ~CLK;

  // Host chip drives the bus whenever it is output-enabled.
  assign DATA = !OE_N ? host_data : 16'hzzzz;
  assign BE   = !OE_N ? host_be   : 2'bzz;

  logic [17:0] rd_src[$];
  logic [17:0] tx_src[$];
  logic [17:0] exp_rx[$];
  int          log_dir[$];
  int          log_len[$];
  bit          rd_en, tx_en, txe_en, pend_rd, pend_tx;
  bit          prev_drv, prev_oe_low, prev_rd_n;
  int          rx_model, tx_model, cur_dir, cur_len, turn_viol, seq_viol;
  int          n_checks, n_pass;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic drive_pins();
    RXF_N         = !(rd_en && rd_src.size() > 0);
    TXE_N         = !txe_en;
    strm.tx_valid = tx_en && tx_src.size() > 0;
    strm.tx_data  = tx_src.size() > 0 ? tx_src[0][15:0] : 16'h0;
    strm.tx_be    = tx_src.size() > 0 ? tx_src[0][17:16] : 2'b00;
    host_data     = rd_src.size() > 0 ? rd_src[0][15:0] : 16'h0;
    host_be       = rd_src.size() > 0 ? rd_src[0][17:16] : 2'b00;
  endtask

  task automatic note(input int dir);
    if (cur_len > 0 && dir != cur_dir) begin
      log_dir.push_back(cur_dir);
      log_len.push_back(cur_len);
      cur_len = 0;
    end
    cur_dir = dir;
    cur_len++;
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge CLK);
      #2;
      quiet = busy ? 0 : quiet + 1;
      n++;
    end
    if (quiet < 4) check("idle_timeout", 1, 0);
  endtask

  task automatic check_log(input string tag, input int idx, input int dir, input int len);
    if (idx < log_dir.size()) begin
      check({tag, "_dir"}, 32'(log_dir[idx]), 32'(dir));
      check({tag, "_len"}, 32'(log_len[idx]), 32'(len));
    end else begin
      check({tag, "_missing"}, 32'(log_dir.size()), 32'(idx + 1));
    end
  endtask

  // Host/pin monitor: applies last edge's effects, predicts the next edge, logs bursts.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST_N) continue;
      if (pend_rd) begin
        void'(rd_src.pop_front());
        rx_model = (rx_model + 1) % 16;
      end
      if (pend_tx) begin
        void'(tx_src.pop_front());
        tx_model = (tx_model + 1) % 16;
      end
      pend_rd = 1'b0;
      pend_tx = 1'b0;
      drive_pins();
      #1;
      if (strm.rx_valid) begin
        if (exp_rx.size() == 0) check("rx_extra", 1, 0);
        else check("rx_word", {14'h0, strm.rx_be, strm.rx_data}, {14'h0, exp_rx.pop_front()});
      end
      if (!OE_N && !RD_N && !RXF_N) begin
        exp_rx.push_back(rd_src[0]);
        pend_rd = 1'b1;
        note(0);
      end
      if (!WR_N) begin
        check("wr_word", {14'h0, BE, DATA}, {14'h0, tx_src[0]});
        pend_tx = 1'b1;
        note(1);
      end
      if ((dut.u_pad.drv_en_i && !OE_N) || (prev_drv && !OE_N) || (prev_oe_low && dut.u_pad.drv_en_i))
        turn_viol++;
      if (!RD_N && (OE_N || (prev_rd_n && !prev_oe_low))) seq_viol++;
      prev_drv    = dut.u_pad.drv_en_i;
      prev_oe_low = !OE_N;
      prev_rd_n   = RD_N;
      if (!busy && cur_len > 0) begin
        log_dir.push_back(cur_dir);
        log_len.push_back(cur_len);
        cur_len = 0;
      end
    end
  end

  initial begin
    strm.rx_space = 1'b1;
    drive_pins();
    repeat (3) @(negedge CLK);
    #2;
    check("rst_oe_n", 32'(OE_N), 1);
    check("rst_rd_n", 32'(RD_N), 1);
    check("rst_wr_n", 32'(WR_N), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_rx_valid", 32'(strm.rx_valid), 0);
    check("rst_tx_ready", 32'(strm.tx_ready), 0);
    check("rst_drive", 32'(dut.u_pad.drv_en_i), 0);
    check("rst_rx_data", {14'h0, strm.rx_be, strm.rx_data}, 0);
    check("rst_words", {24'h0, rx_words, tx_words}, 0);
    RST_N = 1'b1;

    // Contention: both sides always ready, cap 4, read first after reset.
    for (int i = 0; i < 12; i++) begin
      rd_src.push_back({2'(i), 16'h1000 + 16'(i)});
      tx_src.push_back({2'(3 - (i % 4)), 16'h2000 + 16'(i)});
    end
    rd_en = 1'b1; tx_en = 1'b1; txe_en = 1'b1;
    wait_idle(300);
    check("cont_bursts", 32'(log_dir.size()), 6);
    for (int i = 0; i < 6; i++) check_log("cont", i, i % 2, MB);
    check("cont_rx_words", 32'(rx_words), 32'(rx_model));
    check("cont_tx_words", 32'(tx_words), 32'(tx_model));
    log_dir.delete(); log_len.delete();

    // Single read word.
    rd_src.push_back({2'b11, 16'hA55A});
    wait_idle(100);
    check("single_bursts", 32'(log_dir.size()), 1);
    check_log("single", 0, 0, 1);
    check("single_rx_words", 32'(rx_words), 32'(rx_model));
    log_dir.delete(); log_len.delete();

    // Five-word write splits at the cap into 4 + 1.
    for (int i = 1; i <= 5; i++) tx_src.push_back({2'(i), 16'(i)});
    wait_idle(100);
    check("wr5_bursts", 32'(log_dir.size()), 2);
    check_log("wr5_a", 0, 1, MB);
    check_log("wr5_b", 1, 1, 1);
    check("wr5_tx_words", 32'(tx_words), 32'(tx_model));
    log_dir.delete(); log_len.delete();

    // Sink has no space: only the write is served; then reads run until RXF_N rises after 3.
    strm.rx_space = 1'b0;
    for (int i = 0; i < 3; i++) rd_src.push_back({2'b01, 16'hC000 + 16'(i)});
    tx_src.push_back({2'b10, 16'hBEEF});
    tx_src.push_back({2'b11, 16'hCAFE});
    wait_idle(100);
    check("stall_bursts", 32'(log_dir.size()), 1);
    check_log("stall_wr", 0, 1, 2);
    check("stall_rd_left", 32'(rd_src.size()), 3);
    log_dir.delete(); log_len.delete();
    strm.rx_space = 1'b1;
    wait_idle(100);
    check("stall_rd_bursts", 32'(log_dir.size()), 1);
    check_log("stall_rd", 0, 0, 3);
    log_dir.delete(); log_len.delete();

    // 17th read word wraps the 4-bit counter to 1.
    rd_src.push_back({2'b10, 16'h5A5A});
    wait_idle(100);
    check("wrap_rx_words", 32'(rx_words), 1);
    check("wrap_tx_words", 32'(tx_words), 32'(tx_model));
    check("rx_drained", 32'(exp_rx.size()), 0);

    // Reset in the middle of a write burst.
    for (int i = 0; i < 3; i++) tx_src.push_back({2'b11, 16'hD000 + 16'(i)});
    begin
      int n = 0;
      do begin
        @(negedge CLK);
        #2;
        n++;
      end while (WR_N && n < 20);
      check("mid_wr_seen", 32'(WR_N), 0);
    end
    RST_N = 1'b0;
    #1;
    check("mrst_wr_n", 32'(WR_N), 1);
    check("mrst_drive", 32'(dut.u_pad.drv_en_i), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_tx_ready", 32'(strm.tx_ready), 0);
    check("mrst_words", {24'h0, rx_words, tx_words}, 0);
    tx_en = 1'b0;
    tx_src.delete(); rd_src.delete(); exp_rx.delete();
    log_dir.delete(); log_len.delete();
    pend_rd = 1'b0; pend_tx = 1'b0; cur_len = 0;
    rx_model = 0; tx_model = 0;
    drive_pins();
    repeat (2) @(negedge CLK);
    #2;
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    #2;
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_bursts", 32'(log_dir.size()), 0);
    check("turnaround", 32'(turn_viol), 0);
    check("oe_before_rd", 32'(seq_viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
